alu_ctrl_seq: RTL and testbench

Registered, handshaked successor to the combinational ALU control decoder of the 24-bit CPU. It sits between the decode and execute stages. Each accepted op is decoded into a CTRL_W-bit ALUCtrl code, which is held stable until execute consumes it. Multi-cycle ops (MUL) are sequenced internally with a busy counter, and undefined Funct codes are flagged instead of leaving ALUCtrl latched.

---
 rtl/alu_ctrl_seq_if.sv | 41 ++++
 rtl/alu_ctrl_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: decode-to-execute handshake bundle for the ALU control
// sequencer. The master side is the decode stage plus the execute consumer,
// the slave side is alu_ctrl_seq itself.
// Optional macro ALUCTRL_ILLEGAL_TRAP_EN adds the sticky IllegalTrap signal.
interface alu_ctrl_seq_if #(
    parameter int FUNCT_W  = 4,
    parameter int OPCODE_W = 4,
    parameter int CTRL_W   = 4
);
    logic                Flush;
    logic                InValid;
    logic                InReady;
    logic [1:0]          ALUOp;
    logic [FUNCT_W-1:0]  Funct;
    logic [OPCODE_W-1:0] Opcode;
    logic                OutValid;
    logic                OutReady;
    logic [CTRL_W-1:0]   ALUCtrl;
    logic                MultiCycle;
    logic                Busy;
    logic                Illegal;
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
    logic                IllegalTrap;
`endif

    modport master (
        output Flush, InValid, ALUOp, Funct, Opcode, OutReady,
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
        input  IllegalTrap,
`endif
        input  InReady, OutValid, ALUCtrl, MultiCycle, Busy, Illegal
    );

    modport slave (
        input  Flush, InValid, ALUOp, Funct, Opcode, OutReady,
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
        output IllegalTrap,
`endif
        output InReady, OutValid, ALUCtrl, MultiCycle, Busy, Illegal
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU control decoder between decode and
// execute. Single-cycle ops issue one per cycle; MUL occupies the block for
// MUL_CYCLES cycles via a down-counter before its code is presented.
// Optional macro ALUCTRL_ILLEGAL_TRAP_EN: consuming an op with an undefined
// Funct sets a sticky IllegalTrap and halts intake until reset.
module alu_ctrl_seq #(
    parameter int FUNCT_W    = 4,
    parameter int OPCODE_W   = 4,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic        Clock,
    input  logic        ResetN,
    alu_ctrl_seq_if.slave alu_if
);

    localparam int                CNT_W    = $clog2(MUL_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CTRL_W-1:0] NOP      = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULTI = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              mul_q, mul_d;
    logic              ill_q, ill_d;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_mul;
    logic              dec_ill;
    logic              stall;
    logic              in_ready;
    logic              accept;
    logic              consume;

    // 4-bit control codes are zero-extended into the configured width
    function automatic logic [CTRL_W-1:0] zext(input logic [3:0] code);
        return CTRL_W'(code);
    endfunction

    // Combinational decode of the op currently presented by decode
    always_comb begin
        dec_ctrl = zext(4'b0100);
        dec_mul  = 1'b0;
        dec_ill  = 1'b0;
        case (alu_if.ALUOp)
            2'b00: dec_ctrl = zext(4'b0100);
            2'b01: dec_ctrl = zext(4'b1100);
            2'b10: begin
                case (alu_if.Funct)
                    FUNCT_W'(4'b0000): dec_ctrl = zext(4'b0000);
                    FUNCT_W'(4'b0001): dec_ctrl = zext(4'b0001);
                    FUNCT_W'(4'b0010): dec_ctrl = zext(4'b0010);
                    FUNCT_W'(4'b0011): dec_ctrl = zext(4'b1010);
                    FUNCT_W'(4'b0100): dec_ctrl = zext(4'b0011);
                    FUNCT_W'(4'b0110): dec_ctrl = zext(4'b0101);
                    FUNCT_W'(4'b0111): dec_ctrl = zext(4'b0110);
                    default: begin
                        dec_ctrl = NOP;
                        dec_ill  = 1'b1;
                    end
                endcase
            end
            2'b11: begin
                if (alu_if.Opcode == OPCODE_W'(4'b0110)) begin
                    dec_ctrl = zext(4'b0111);
                    dec_mul  = 1'b1;
                end else begin
                    dec_ctrl = zext(4'b0100);
                end
            end
            default: dec_ctrl = zext(4'b0100);
        endcase
    end

`ifdef ALUCTRL_ILLEGAL_TRAP_EN
    logic trap_q, trap_d;

    assign stall = trap_q;

    // Trap latches once an illegal op has actually been handed to execute
    always_comb begin
        trap_d = trap_q | (consume & ill_q);
    end

    // Sticky trap flag, cleared only by reset
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign alu_if.IllegalTrap = trap_q;
`else
    assign stall = 1'b0;
`endif

    // Intake is open when idle, or when the held code leaves this cycle
    assign in_ready = ((state_q == S_IDLE) ||
                       ((state_q == S_OUT) && alu_if.OutReady)) && !stall;
    // Flush suppresses both intake and consumption in the same cycle
    assign accept   = alu_if.InValid && in_ready && !alu_if.Flush;
    assign consume  = (state_q == S_OUT) && alu_if.OutReady && !alu_if.Flush;

    // Next-state logic: flush first, then a new op, then state-specific moves
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        mul_d   = mul_q;
        ill_d   = ill_q;
        if (alu_if.Flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ctrl_d  = NOP;
            mul_d   = 1'b0;
            ill_d   = 1'b0;
        end else if (accept) begin
            ctrl_d = dec_ctrl;
            mul_d  = dec_mul;
            ill_d  = dec_ill;
            if (dec_mul) begin
                state_d = S_MULTI;
                cnt_d   = CNT_LOAD;
            end else begin
                state_d = S_OUT;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_MULTI: begin
                    // Counter stops at zero so it can never wrap
                    if (cnt_q == '0) begin
                        state_d = S_OUT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (alu_if.OutReady) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counter and held decode registers
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= NOP;
            mul_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            mul_q   <= mul_d;
            ill_q   <= ill_d;
        end
    end

    assign alu_if.InReady    = in_ready;
    assign alu_if.OutValid   = (state_q == S_OUT);
    assign alu_if.Busy       = (state_q == S_MULTI);
    assign alu_if.ALUCtrl    = ctrl_q;
    assign alu_if.MultiCycle = mul_q;
    assign alu_if.Illegal    = ill_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: scoreboard bench for alu_ctrl_seq. Expected codes come
// from an independent table model, queued on acceptance and popped on
// consumption. Build with ALUCTRL_ILLEGAL_TRAP_EN to cover the trap.
module tb_alu_ctrl_seq;

    localparam int FUNCT_W    = 4;
    localparam int OPCODE_W   = 4;
    localparam int CTRL_W     = 4;
    localparam int MUL_CYCLES = 4;

    logic Clock = 1'b0;
    logic ResetN;

    always #5 Clock = ~Clock;

    alu_ctrl_seq_if #(.FUNCT_W(FUNCT_W), .OPCODE_W(OPCODE_W), .CTRL_W(CTRL_W)) bus ();

    alu_ctrl_seq #(
        .FUNCT_W(FUNCT_W), .OPCODE_W(OPCODE_W),
        .CTRL_W(CTRL_W), .MUL_CYCLES(MUL_CYCLES)
    ) u_dut (
        .Clock (Clock),
        .ResetN(ResetN),
        .alu_if(bus)
    );

    typedef struct packed {
        logic              ill;
        logic              mul;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_cons = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference decode table
    function automatic exp_t ref_decode(input logic [1:0] a, input logic [3:0] f, input logic [3:0] o);
        exp_t e;
        e.ill  = 1'b0;
        e.mul  = 1'b0;
        e.ctrl = 4'h4;
        if (a == 2'b01) begin
            e.ctrl = 4'hC;
        end else if (a == 2'b10) begin
            case (f)
                4'd0: e.ctrl = 4'h0;
                4'd1: e.ctrl = 4'h1;
                4'd2: e.ctrl = 4'h2;
                4'd3: e.ctrl = 4'hA;
                4'd4: e.ctrl = 4'h3;
                4'd6: e.ctrl = 4'h5;
                4'd7: e.ctrl = 4'h6;
                default: begin
                    e.ctrl = 4'hF;
                    e.ill  = 1'b1;
                end
            endcase
        end else if (a == 2'b11 && o == 4'd6) begin
            e.ctrl = 4'h7;
            e.mul  = 1'b1;
        end
        return e;
    endfunction

    // Scoreboard: pop on consumption, push on acceptance, sampled mid-cycle
    always @(negedge Clock) begin
        exp_t e;
        if (!ResetN || bus.Flush) begin
            sb_q.delete();
        end else begin
            if (bus.OutValid && bus.OutReady) begin
                n_cons++;
                check_eq("sb_nonempty", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("sb_ctrl", bus.ALUCtrl, e.ctrl);
                    check_eq("sb_mul", bus.MultiCycle, e.mul);
                    check_eq("sb_ill", bus.Illegal, e.ill);
                end
            end
            if (bus.InValid && bus.InReady)
                sb_q.push_back(ref_decode(bus.ALUOp, bus.Funct, bus.Opcode));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Present one op and hold it until it is accepted (bounded wait)
    task automatic drive_op(input logic [1:0] a, input logic [3:0] f, input logic [3:0] o);
        int n;
        n = 0;
        bus.InValid = 1'b1;
        bus.ALUOp   = a;
        bus.Funct   = f;
        bus.Opcode  = o;
        @(negedge Clock);
        while (!bus.InReady && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check_eq("accept_rdy", bus.InReady, 1);
        @(posedge Clock);
        #1;
        bus.InValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy_cnt, rdy_bad, c0;
        logic [3:0] legal [7];
        legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};

        ResetN       = 1'b0;
        bus.Flush    = 1'b0;
        bus.InValid  = 1'b0;
        bus.ALUOp    = 2'b00;
        bus.Funct    = '0;
        bus.Opcode   = '0;
        bus.OutReady = 1'b1;
        tick(2);
        check_eq("rst_vld", bus.OutValid, 0);
        check_eq("rst_busy", bus.Busy, 0);
        check_eq("rst_ctrl", bus.ALUCtrl, 4'hF);
        check_eq("rst_mul", bus.MultiCycle, 0);
        check_eq("rst_ill", bus.Illegal, 0);
        ResetN = 1'b1;
        check_eq("rst_rdy", bus.InReady, 1);

        // Back-to-back single-cycle R-format ops
        drive_op(2'b10, 4'd2, 4'd0);
        check_eq("b2b_vld0", bus.OutValid, 1);
        drive_op(2'b10, 4'd3, 4'd0);
        check_eq("b2b_vld1", bus.OutValid, 1);
        drive_op(2'b10, 4'd7, 4'd0);
        check_eq("b2b_vld2", bus.OutValid, 1);
        check_eq("b2b_ctrl2", bus.ALUCtrl, 4'h6);
        tick(1);
        check_eq("b2b_idle", bus.OutValid, 0);
        check_eq("keep_last", bus.ALUCtrl, 4'h6);

        // Legal decode sweep plus the other ALUOp classes
        for (int i = 0; i < 7; i++) drive_op(2'b10, legal[i], 4'd0);
        drive_op(2'b01, 4'd0, 4'd0);
        drive_op(2'b11, 4'd0, 4'd3);
        drive_op(2'b00, 4'd9, 4'd9);
        tick(2);

        // MUL occupancy and latency
        drive_op(2'b11, 4'd0, 4'd6);
        n = 0; busy_cnt = 0; rdy_bad = 0;
        while (!bus.OutValid && n < 20) begin
            if (bus.Busy) busy_cnt++;
            if (bus.InReady) rdy_bad++;
            tick(1);
            n++;
        end
        check_eq("mul_lat", n, MUL_CYCLES);
        check_eq("mul_busy_cnt", busy_cnt, MUL_CYCLES);
        check_eq("mul_rdy_low", rdy_bad, 0);
        check_eq("mul_busy_off", bus.Busy, 0);
        check_eq("mul_ctrl", bus.ALUCtrl, 4'h7);
        check_eq("mul_flag", bus.MultiCycle, 1);
        tick(2);

        // Backpressure: held code stays stable and is consumed once
        bus.OutReady = 1'b0;
        drive_op(2'b00, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_ctrl", bus.ALUCtrl, 4'h4);
            check_eq("bp_vld", bus.OutValid, 1);
            check_eq("bp_rdy", bus.InReady, 0);
            tick(1);
        end
        c0 = n_cons;
        bus.OutReady = 1'b1;
        tick(3);
        check_eq("bp_once", n_cons - c0, 1);

        // Asynchronous reset in the middle of a MUL
        drive_op(2'b11, 4'd0, 4'd6);
        tick(1);
        #2 ResetN = 1'b0;
        #1;
        check_eq("rmul_vld", bus.OutValid, 0);
        check_eq("rmul_busy", bus.Busy, 0);
        check_eq("rmul_ctrl", bus.ALUCtrl, 4'hF);
        tick(1);
        ResetN = 1'b1;
        check_eq("rmul_rdy", bus.InReady, 1);
        tick(6);
        check_eq("rmul_abort", bus.OutValid, 0);

        // Flush during MULTI together with a new op
        drive_op(2'b11, 4'd0, 4'd6);
        tick(1);
        bus.Flush   = 1'b1;
        bus.InValid = 1'b1;
        bus.ALUOp   = 2'b00;
        tick(1);
        bus.Flush   = 1'b0;
        bus.InValid = 1'b0;
        check_eq("flm_vld", bus.OutValid, 0);
        check_eq("flm_busy", bus.Busy, 0);
        check_eq("flm_ctrl", bus.ALUCtrl, 4'hF);
        check_eq("flm_rdy", bus.InReady, 1);
        tick(3);
        check_eq("flm_noacc", bus.OutValid, 0);

        // Flush in OUT beats a simultaneous handshake
        bus.OutReady = 1'b0;
        drive_op(2'b00, 4'd0, 4'd0);
        bus.Flush    = 1'b1;
        bus.InValid  = 1'b1;
        bus.ALUOp    = 2'b10;
        bus.Funct    = 4'd2;
        bus.OutReady = 1'b1;
        tick(1);
        bus.Flush   = 1'b0;
        bus.InValid = 1'b0;
        check_eq("flo_vld", bus.OutValid, 0);
        check_eq("flo_ctrl", bus.ALUCtrl, 4'hF);
        tick(2);
        check_eq("flo_noacc", bus.OutValid, 0);

        // Illegal Funct
        bus.OutReady = 1'b0;
        drive_op(2'b10, 4'd5, 4'd0);
        check_eq("ill_flag", bus.Illegal, 1);
        check_eq("ill_ctrl", bus.ALUCtrl, 4'hF);
        check_eq("ill_vld", bus.OutValid, 1);
        bus.OutReady = 1'b1;
        tick(1);
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
        check_eq("trap_set", bus.IllegalTrap, 1);
        check_eq("trap_rdy", bus.InReady, 0);
        tick(3);
        check_eq("trap_sticky", bus.IllegalTrap, 1);
        check_eq("trap_halt", bus.InReady, 0);
        ResetN = 1'b0;
        tick(1);
        ResetN = 1'b1;
        check_eq("trap_clr", bus.IllegalTrap, 0);
        check_eq("trap_rdy_rst", bus.InReady, 1);
`else
        check_eq("ill_nostall", bus.InReady, 1);
        for (int f = 0; f < 16; f++) drive_op(2'b10, 4'(f), 4'd0);
        tick(2);
`endif

        check_eq("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
